// File: rtl/mem_responder.sv
// Memory-side responder for the MAR/MDR datapath: one request at a time,
// a programmable wait, then a single access on an internal 32-bit word RAM.
module mem_responder #(
  parameter int ADDR_W      = 9,
  parameter int WAIT_STATES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  state_dbg
);

  // Handshake: the initiator holds exactly one of read/write (with addr and
  // wdata stable) until it sees done, then drops it at the next edge; any
  // request present in IDLE is accepted, requests in WAIT/DONE are ignored.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                err_q, err_d;
  logic [31:0]         rdata_q;

  logic                req_valid;
  logic                req_bad;
  logic                commit;
  logic [ADDR_W-1:0]   acc_addr;
  logic [31:0]         acc_wdata;
  logic                acc_we;

  logic [31:0]         mem [2**ADDR_W];

  always_comb begin
    req_valid = (read ^ write) && (addr[31:ADDR_W] == '0);
    req_bad   = (read | write) && !req_valid;

    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    err_d     = 1'b0;
    commit    = 1'b0;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_we    = we_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = addr[ADDR_W-1:0];
          wdata_d = wdata;
          we_d    = write;
          cnt_d   = '0;
          if (WAIT_STATES == 0) begin
            // Zero-wait: access straight from the inputs on the accepting edge.
            commit    = 1'b1;
            acc_addr  = addr[ADDR_W-1:0];
            acc_wdata = wdata;
            acc_we    = write;
            state_d   = S_DONE;
          end else begin
            state_d = S_WAIT;
          end
        end else if (req_bad) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          commit  = 1'b1;
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
      if (commit && !acc_we) begin
        rdata_q <= mem[acc_addr];
      end
    end
  end

  // RAM is never cleared; reset only blocks a commit that coincides with it.
  always_ff @(posedge clock) begin
    if (!reset && commit && acc_we) begin
      mem[acc_addr] <= acc_wdata;
    end
  end

  assign rdata     = rdata_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign state_dbg = state_q;

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the processor's MAR/MDR datapath. It accepts a single read or write request, addressed by the MAR value and carrying the MDR value as write data. It waits a programmable number of cycles and then performs the access on an internal 32-bit word RAM. It returns read data on the line that feeds the MDR's memory-data input, together with a one-cycle completion pulse. It is the far end of the memory interface the control unit drives through MDR/MAR.

## Interface
- ADDR_W, 9: word-address width; RAM depth is 2^ADDR_W words of 32 bits.
- WAIT_STATES, 2: cycles spent in WAIT before the access commits (0 allowed).
- clock, in, 1: single clock; all state updates on the rising edge.
- reset, in, 1: synchronous, active-high.
- read, in, 1: read request level from the control unit.
- write, in, 1: write request level from the control unit.
- addr, in, 32: word address from MAR.
- wdata, in, 32: write data from the MDR output.
- rdata, out, 32: read data to the MDR memory-data input (registered).
- busy, out, 1: high while a request is in progress (states WAIT and DONE).
- done, out, 1: one-cycle completion pulse.
- err, out, 1: qualifies done; high when the request was rejected.

## Operation
- There are three states: IDLE, WAIT and DONE. An internal wait counter counts up to WAIT_STATES. The block also holds latched copies of addr, wdata and op.
- Requests are sampled only in IDLE. Requests in WAIT or DONE are ignored, not queued.
- IDLE, valid request (exactly one of read/write is high, and addr[31:ADDR_W] == 0):
  - Latch addr[ADDR_W-1:0], wdata and op.
  - If WAIT_STATES > 0, go to WAIT with the counter at 0. Otherwise commit immediately and go to DONE.
- WAIT: the counter increments each cycle. At the edge where counter == WAIT_STATES-1, commit and go to DONE.
- Commit:
  - For a write, RAM[latched addr] <= latched wdata.
  - For a read, rdata <= RAM[latched addr].
  - Commit happens on the same edge that enters DONE.
- DONE: done = 1 for exactly one cycle, err = 0, then go unconditionally to IDLE.
- IDLE, invalid request (read and write both high, or a nonzero upper address bit):
  - Go directly to DONE with err = 1.
  - No RAM access; rdata unchanged; latched registers unchanged.
- rdata holds its value until the next successful read commits. Writes and errors never change it.
- A write followed by a read of the same address returns the newly written data; no bypass hazard exists.
- RAM contents are not cleared by reset and are undefined until written.

## Timing
- Reset values: state = IDLE, rdata = 0, busy = 0, done = 0, err = 0, counter = 0.
- Reset asserted in WAIT aborts the request. No write is committed and rdata is unchanged by the aborted read. The state is IDLE in the following cycle.
- Reset asserted in DONE clears done and err in the next cycle. A write already committed on entry to DONE stays committed.
- Latency, valid request: the request is sampled at edge k. busy = 1 from cycle k+1. done = 1 in cycle k+1+WAIT_STATES. rdata is valid in that same cycle and after.
- Latency, invalid request: done = err = 1 in cycle k+1. busy = 1 in that cycle only.
- Handshake: the initiator holds read or write until it sees done, then drops the request at the next edge. Because DONE always returns to IDLE, a request still high in IDLE is treated as a new request.
- busy, done and err are pure functions of registered state; no combinational path from the inputs.

## Test plan
- Reset: assert reset for 2 cycles with read = 1 held -> rdata = 0, busy = 0, done = 0, err = 0 throughout; no request accepted while reset is high.
- Write/read timing (WAIT_STATES = 2):
  - Write 0xDEADBEEF to addr 5 -> done at k+3.
  - Then read addr 5 -> done at k'+3 with rdata = 0xDEADBEEF; busy high for exactly 3 cycles each time.
- Zero wait (WAIT_STATES = 0): read addr 5 after writing 0x12345678 -> done and rdata = 0x12345678 in cycle k+1.
- Errors:
  - read = write = 1 -> done = err = 1 at k+1; RAM and rdata unchanged.
  - addr = 0x0000_0200 with ADDR_W = 9 -> same response; a following read of addr 0 is unaffected.
- Abort: write 0xCAFEF00D to addr 7 (old value 0x11111111); assert reset in the first WAIT cycle -> no done pulse; a later read of addr 7 returns 0x11111111.
- Busy ignore: issue a read of addr 3; pulse write with addr 4 during WAIT -> only the read completes; RAM[4] unchanged; exactly one done pulse.
